// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: fetch handshake, opcode decode, EXEC/MEM/WB/BRANCH
// sequencing with a per-state control word, memory timeout and sticky fault.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      instr,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             alu_zero,
    input  logic             flag_lt,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       imm_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             flag_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             fault
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_BRANCH,
        S_FAULT
    } state_t;

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   wait_reg, wait_next, wait_inc;
    logic [CNT_W-1:0]    cnt_reg;

    // Opcode classes, decoded straight from the IR contents
    logic op_adds, op_subs, op_addi, op_ldur, op_stur, op_cbz, op_b, op_blt;
    logic is_r, is_mem, is_br;

    assign op_adds = (instr[31:21] == 11'b10101011000);
    assign op_subs = (instr[31:21] == 11'b11101011000);
    assign op_addi = (instr[31:22] == 10'b1001000100);
    assign op_ldur = (instr[31:21] == 11'b11111000010);
    assign op_stur = (instr[31:21] == 11'b11111000000);
    assign op_cbz  = (instr[31:24] == 8'b10110100);
    assign op_b    = (instr[31:26] == 6'b000101);
    assign op_blt  = (instr[31:24] == 8'b01010100) && (instr[4:0] == 5'b01011);

    assign is_r   = op_adds | op_subs;
    assign is_mem = op_ldur | op_stur;
    assign is_br  = op_cbz | op_b | op_blt;

    assign wait_inc    = wait_reg + WAIT_W'(1);
    assign retired_cnt = cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_FETCH;
            wait_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (retire)
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        wait_next  = '0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        imm_sel    = 2'd0;
        alu_src    = 1'b0;
        alu_op     = 2'd0;
        flag_write = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        fault      = 1'b0;

        case (state_reg)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    // Counter leaves FETCH/MEM at zero, so it is clear on every entry
                    wait_next = wait_inc;
                    if (wait_inc == WAIT_W'(TIMEOUT))
                        state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                if (is_r || op_addi || is_mem)
                    state_next = S_EXEC;
                else if (is_br)
                    state_next = S_BRANCH;
                else
                    state_next = S_FAULT;
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_op     = op_subs ? 2'd1 : 2'd0;
                    flag_write = 1'b1;
                end else if (op_addi) begin
                    imm_sel = 2'd3;
                    alu_src = 1'b1;
                end else begin
                    alu_src = 1'b1;
                end
                state_next = is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = op_stur;
                if (dmem_ready) begin
                    if (op_stur) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else begin
                    wait_next = wait_inc;
                    if (wait_inc == WAIT_W'(TIMEOUT))
                        state_next = S_FAULT;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = op_ldur;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                pc_src     = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
                if (op_cbz) begin
                    imm_sel  = 2'd1;
                    alu_op   = 2'd2;
                    pc_write = alu_zero;
                end else if (op_blt) begin
                    imm_sel  = 2'd1;
                    pc_write = flag_lt;
                end else begin
                    imm_sel  = 2'd2;
                    pc_write = 1'b1;
                end
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = S_FAULT;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected control word for
// every driven cycle; a monitor pops and compares it against the DUT outputs.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 2;

    localparam int K_ADDS = 0, K_SUBS = 1, K_ADDI = 2, K_LDUR = 3, K_STUR = 4;
    localparam int K_CBZ  = 5, K_BLT  = 6, K_B    = 7, K_BAD  = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [31:0]      instr;
    logic             imem_ready, dmem_ready, alu_zero, flag_lt;
    logic             imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
    logic [1:0]       imm_sel, alu_op;
    logic             alu_src, flag_write, reg_write, mem_to_reg, retire, fault;
    logic [CNT_W-1:0] retired_cnt;

    typedef struct packed {
        logic             imem_req;
        logic             dmem_req;
        logic             dmem_we;
        logic             ir_write;
        logic             pc_write;
        logic             pc_src;
        logic [1:0]       imm_sel;
        logic             alu_src;
        logic [1:0]       alu_op;
        logic             flag_write;
        logic             reg_write;
        logic             mem_to_reg;
        logic             retire;
        logic             fault;
        logic [CNT_W-1:0] cnt;
    } ctl_t;

    ctl_t  act;
    ctl_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passes = 0;
    int    exp_cnt = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .instr(instr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .alu_zero(alu_zero), .flag_lt(flag_lt),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .imm_sel(imm_sel), .alu_src(alu_src), .alu_op(alu_op),
        .flag_write(flag_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .retire(retire), .retired_cnt(retired_cnt), .fault(fault)
    );

    assign act = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, imm_sel,
                  alu_src, alu_op, flag_write, reg_write, mem_to_reg, retire, fault,
                  retired_cnt};

    // Monitor: one comparison per cycle that has an expectation queued
    initial begin
        ctl_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (act !== e)
                    $display("FAIL %s: got %h, expected %h", nm, act, e);
                else begin
                    passes++;
                    $display("ok   %s: %h", nm, act);
                end
            end
        end
    end

    // Queue the expected outputs for the current cycle, then advance one clock
    task automatic step(input ctl_t v, input string nm);
        v.cnt = exp_cnt[CNT_W-1:0];
        exp_q.push_back(v);
        name_q.push_back(nm);
        if (!reset_n)
            exp_cnt = 0;
        else if (v.retire)
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] iw, input int waits, input string nm);
        ctl_t v;
        instr = iw;
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            v = '0; v.imem_req = 1'b1;
            step(v, {nm, ":fetch_wait"});
        end
        imem_ready = 1'b1;
        v = '0; v.imem_req = 1'b1; v.ir_write = 1'b1; v.pc_write = 1'b1;
        step(v, {nm, ":fetch"});
        imem_ready = 1'b0;
        v = '0;
        step(v, {nm, ":decode"});
    endtask

    task automatic exec_cycle(input int kind, input string nm);
        ctl_t v;
        v = '0;
        case (kind)
            K_ADDS: v.flag_write = 1'b1;
            K_SUBS: begin v.flag_write = 1'b1; v.alu_op = 2'd1; end
            K_ADDI: begin v.imm_sel = 2'd3; v.alu_src = 1'b1; end
            default: v.alu_src = 1'b1;
        endcase
        step(v, {nm, ":exec"});
    endtask

    task automatic run(input string nm, input logic [31:0] iw, input int kind,
                       input int iwait, input int dwait, input logic cond);
        ctl_t v;
        fetch(iw, iwait, nm);
        if (kind == K_BAD) begin
            for (int i = 0; i < 3; i++) begin
                imem_ready = (i == 1);
                v = '0; v.fault = 1'b1;
                step(v, {nm, ":fault"});
            end
            imem_ready = 1'b0;
        end else if (kind == K_CBZ || kind == K_BLT || kind == K_B) begin
            alu_zero = (kind == K_CBZ) ? cond : ((kind == K_BLT) ? ~cond : 1'b0);
            flag_lt  = (kind == K_BLT) ? cond : ((kind == K_CBZ) ? ~cond : 1'b0);
            v = '0;
            v.imm_sel  = (kind == K_B) ? 2'd2 : 2'd1;
            v.alu_op   = (kind == K_CBZ) ? 2'd2 : 2'd0;
            v.pc_write = (kind == K_B) ? 1'b1 : cond;
            v.pc_src   = 1'b1;
            v.retire   = 1'b1;
            step(v, {nm, ":branch"});
            alu_zero = 1'b0;
            flag_lt  = 1'b0;
        end else begin
            exec_cycle(kind, nm);
            if (kind == K_LDUR || kind == K_STUR) begin
                for (int i = 0; i < dwait; i++) begin
                    dmem_ready = 1'b0;
                    v = '0; v.dmem_req = 1'b1; v.dmem_we = (kind == K_STUR);
                    step(v, {nm, ":mem_wait"});
                end
                dmem_ready = 1'b1;
                v = '0; v.dmem_req = 1'b1; v.dmem_we = (kind == K_STUR);
                v.retire = (kind == K_STUR);
                step(v, {nm, ":mem"});
                dmem_ready = 1'b0;
            end
            if (kind != K_STUR) begin
                v = '0; v.reg_write = 1'b1; v.mem_to_reg = (kind == K_LDUR); v.retire = 1'b1;
                step(v, {nm, ":wb"});
            end
        end
    endtask

    initial begin
        ctl_t v;
        reset_n = 1'b0; instr = '0;
        imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0; flag_lt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        v = '0; v.imem_req = 1'b1;
        step(v, "reset_state");
        reset_n = 1'b1;

        run("addi",      32'h91001401, K_ADDI, 0, 0, 1'b0);
        run("subs",      32'hEB020020, K_SUBS, 0, 0, 1'b0);
        run("ldur_w3",   32'hF8400020, K_LDUR, 0, 3, 1'b0);
        run("stur",      32'hF8000020, K_STUR, 0, 0, 1'b0);   // counter wraps 3 -> 0
        run("cbz_taken", 32'hB4000041, K_CBZ,  0, 0, 1'b1);
        run("cbz_not",   32'hB4000041, K_CBZ,  0, 0, 1'b0);

        // Reset held three cycles while a load sits in MEM
        fetch(32'hF8400020, 0, "rst_mid");
        exec_cycle(K_LDUR, "rst_mid");
        v = '0; v.dmem_req = 1'b1;
        step(v, "rst_mid:mem_wait");
        reset_n = 1'b0;
        step(v, "rst_mid:mem_in_reset");
        v = '0; v.imem_req = 1'b1;
        step(v, "rst_mid:reset2");
        step(v, "rst_mid:reset3");
        reset_n = 1'b1;
        step(v, "rst_mid:fetch_after");

        run("b",         32'h14000003, K_B,    0, 0, 1'b1);
        run("blt_taken", 32'h5400004B, K_BLT,  0, 0, 1'b1);
        run("blt_not",   32'h5400004B, K_BLT,  0, 0, 1'b0);
        run("adds_iw2",  32'hAB020020, K_ADDS, 2, 0, 1'b0);
        run("stur_w1",   32'hF8000020, K_STUR, 0, 1, 1'b0);

        run("illegal",   32'hFFFFFFFF, K_BAD,  0, 0, 1'b0);
        reset_n = 1'b0;
        v = '0; v.fault = 1'b1;
        step(v, "illegal:reset");
        reset_n = 1'b1;

        // Instruction fetch never answers
        for (int i = 0; i < TIMEOUT; i++) begin
            v = '0; v.imem_req = 1'b1;
            step(v, "imem_timeout:wait");
        end
        v = '0; v.fault = 1'b1;
        imem_ready = 1'b1;
        step(v, "imem_timeout:fault");
        imem_ready = 1'b0;
        step(v, "imem_timeout:sticky");
        reset_n = 1'b0;
        step(v, "imem_timeout:reset");
        reset_n = 1'b1;

        // Data memory never answers
        fetch(32'hF8400020, 0, "dmem_timeout");
        exec_cycle(K_LDUR, "dmem_timeout");
        for (int i = 0; i < TIMEOUT; i++) begin
            v = '0; v.dmem_req = 1'b1;
            step(v, "dmem_timeout:wait");
        end
        v = '0; v.fault = 1'b1;
        step(v, "dmem_timeout:fault");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
